sim_frame_trigger: RTL and testbench
====================================

Name: sim_frame_trigger

Overview:
- Synthesizable producer of the frame count and dump-window control consumed by the simulation dump block.
- Watches the raw vertical sync and the download indicator, counts frames, and raises a dump-enable window over a programmed frame range.
- Sits in the test harness beside the game top level. Its outputs are also usable on hardware as a frame-accurate debug trigger, for example for a logic analyser.

Parameters:
- START_FRAME, 32'd0: frame_cnt value at which the window opens.
- LEN_FRAMES, 32'd0: window length in frames. 0 means the window never closes on its own.
- WAIT_DL, 1: 1 means the trigger is not armed until a download completes (falling edge of led). 0 means it is armed straight after reset.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- VGA_VS  in  1  vertical sync, asynchronous to clk, active-low pulse
- led  in  1  download-in-progress flag, asynchronous, high while downloading
- rearm  in  1  one-cycle pulse that re-arms the trigger from DONE
- frame_cnt  out  32  frames counted since the last reset or download
- vs_fall  out  1  one-cycle pulse per synchronized falling edge of VGA_VS
- dump_en  out  1  level, high while the dump window is open
- dump_start  out  1  one-cycle pulse when the window opens
- dump_stop  out  1  one-cycle pulse when the window closes or is aborted
- state  out  3  current FSM state, for debug

Behaviour:
- Reset: clk is the only clock. rst_n is asynchronous and active-low. While rst_n is low every output is 0 and every synchronizer flop is cleared. The FSM resets to IDLE.
- Synchronizers: VGA_VS and led each pass through a 2-flop synchronizer plus one history flop.
  - vs_fall is asserted 3 clk cycles after VGA_VS is first sampled low.
  - led_fall and led_rise are internal one-cycle pulses derived the same way.
  - Pulses shorter than 1 clk may be missed; this is not required to be handled.
- frame_cnt:
  - Increments by 1 in the cycle vs_fall is high and is visible on the following cycle.
  - Wraps from 32'hFFFFFFFF to 0.
  - Forced to 0 and held there while the synchronized led is high. Clearing has priority over incrementing.
- Comparisons: all window comparisons use the pre-increment frame_cnt value in the vs_fall cycle.
  - Stop value = START_FRAME + LEN_FRAMES, computed as a 32-bit modular sum.
- FSM states (3-bit encoding): IDLE=0, WAIT_DL=1, ARMED=2, DUMP=3, DONE=4.
- IDLE: in the first cycle after reset, go to WAIT_DL if WAIT_DL=1, otherwise to ARMED.
- WAIT_DL: on led_fall go to ARMED.
- ARMED: on vs_fall with frame_cnt==START_FRAME, go to DUMP and pulse dump_start in that same cycle. dump_en rises on the next cycle.
- DUMP:
  - dump_en is held at 1.
  - If LEN_FRAMES != 0, then on vs_fall with frame_cnt==stop value: go to DONE, pulse dump_stop, and drop dump_en on the next cycle.
- DONE: dump_en is 0. A rearm pulse moves the FSM to ARMED. Otherwise it stays in DONE.
- Download abort: led_rise in any state other than IDLE forces the FSM to WAIT_DL.
  - If the FSM was in DUMP, dump_stop also pulses.
  - The abort takes priority over every other transition in that cycle.
- Other simultaneous events:
  - rearm outside DONE is ignored.
  - rearm in the same cycle as led_rise: the abort wins.
- Never both pulse: dump_start and dump_stop are never high in the same cycle.
- Repeated match after wrap: while ARMED, START_FRAME matches again after the counter wraps. This is intended.

Decomposition:
- Shared package sim_trig_pkg holds:
  - the FSM state enum and its 3-bit encoding;
  - the FRAME_W=32 constant.
- One natural sub-module, sim_edge_sync: 2-flop synchronizer plus edge detector. It outputs the synchronized level, a rise pulse and a fall pulse. It is instantiated twice, once for VGA_VS and once for led.

Test Plan:
- WAIT_DL=0, START=2, LEN=3, 8 VS pulses:
  - dump_start is high in the vs_fall cycle where frame_cnt=2;
  - dump_en is high for frame_cnt 3..5;
  - dump_stop is high at frame_cnt=5;
  - state ends at 4.
- WAIT_DL=1, led high for 1000 clk with VS toggling:
  - frame_cnt stays 0 and state stays 1;
  - after led falls, state=2 and counting starts from 0.
- START=0, LEN=0: dump_start on the first vs_fall after arming; dump_en stays high for 50 frames.
- In DUMP, raise led:
  - one dump_stop pulse;
  - dump_en drops;
  - frame_cnt reads 0;
  - state=1.
- Reach DONE, pulse rearm, then force frame_cnt to 32'hFFFFFFFF via VS pulses (hierarchical preload allowed):
  - frame_cnt wraps to 0;
  - the window reopens when it reaches START again.
- Assert rst_n low mid-DUMP:
  - all outputs are 0 immediately, without waiting for clk;
  - after release the FSM restarts from IDLE.

Source files
------------

// File: rtl/sim_trig_pkg.sv
// Shared definitions for the simulation frame trigger: frame counter width,
// FSM state encoding and the window stop-value helper.
package sim_trig_pkg;

  localparam int FRAME_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT_DL = 3'd1,
    ST_ARMED   = 3'd2,
    ST_DUMP    = 3'd3,
    ST_DONE    = 3'd4
  } trig_state_e;

  // Modular sum: a window that runs past the counter wrap closes after the wrap.
  function automatic logic [FRAME_W-1:0] stop_frame(input logic [FRAME_W-1:0] start,
                                                    input logic [FRAME_W-1:0] len);
    return start + len;
  endfunction

endpackage

// File: rtl/sim_edge_sync.sv
// Two-flop synchronizer with a history flop; emits the synchronized level
// and registered one-cycle rise/fall pulses.
module sim_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta_r;
  logic sync_r;
  logic hist_r;
  logic rise_r;
  logic fall_r;

  // Synchronizer chain plus registered edge pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
      hist_r <= 1'b0;
      rise_r <= 1'b0;
      fall_r <= 1'b0;
    end else begin
      meta_r <= din;
      sync_r <= meta_r;
      hist_r <= sync_r;
      rise_r <= sync_r & ~hist_r;
      fall_r <= ~sync_r & hist_r;
    end
  end

  assign level = sync_r;
  assign rise  = rise_r;
  assign fall  = fall_r;

endmodule

// File: rtl/sim_frame_trigger.sv
// Frame counter and dump-window trigger driven by the raw vertical sync and
// the download-in-progress flag; doubles as a frame-accurate debug trigger.
module sim_frame_trigger
  import sim_trig_pkg::*;
#(
  parameter logic [FRAME_W-1:0] START_FRAME = 32'd0,
  parameter logic [FRAME_W-1:0] LEN_FRAMES  = 32'd0,
  parameter bit                 WAIT_DL     = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               VGA_VS,
  input  logic               led,
  input  logic               rearm,
  output logic [FRAME_W-1:0] frame_cnt,
  output logic               vs_fall,
  output logic               dump_en,
  output logic               dump_start,
  output logic               dump_stop,
  output logic [2:0]         state
);

  localparam logic [FRAME_W-1:0] STOP_FRAME = stop_frame(START_FRAME, LEN_FRAMES);

  logic vs_level_s;
  logic vs_rise_s;
  logic vs_fall_s;
  logic led_level_s;
  logic led_rise_s;
  logic led_fall_s;
  logic unused_vs_s;

  logic [FRAME_W-1:0] frame_cnt_r;
  trig_state_e        state_r;
  trig_state_e        state_nxt_s;
  logic               dump_en_r;
  logic               dump_start_s;
  logic               dump_stop_s;
  logic               start_hit_s;
  logic               stop_hit_s;

  sim_edge_sync u_vs_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (VGA_VS),
    .level (vs_level_s),
    .rise  (vs_rise_s),
    .fall  (vs_fall_s)
  );

  sim_edge_sync u_led_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (led),
    .level (led_level_s),
    .rise  (led_rise_s),
    .fall  (led_fall_s)
  );

  assign unused_vs_s = vs_level_s ^ vs_rise_s;

  // Window matches use the count before this frame's increment.
  assign start_hit_s = vs_fall_s && (frame_cnt_r == START_FRAME);
  assign stop_hit_s  = vs_fall_s && (LEN_FRAMES != 32'd0) && (frame_cnt_r == STOP_FRAME);

  // Frame counter: download clear beats increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_r <= 32'd0;
    end else if (led_level_s) begin
      frame_cnt_r <= 32'd0;
    end else if (vs_fall_s) begin
      frame_cnt_r <= frame_cnt_r + 32'd1;
    end else begin
      frame_cnt_r <= frame_cnt_r;
    end
  end

  // Next-state and window pulses; a download start aborts from any active state
  always_comb begin
    state_nxt_s  = state_r;
    dump_start_s = 1'b0;
    dump_stop_s  = 1'b0;
    if (led_rise_s && (state_r != ST_IDLE)) begin
      state_nxt_s = ST_WAIT_DL;
      if (state_r == ST_DUMP) begin
        dump_stop_s = 1'b1;
      end else begin
        dump_stop_s = 1'b0;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (WAIT_DL) begin
            state_nxt_s = ST_WAIT_DL;
          end else begin
            state_nxt_s = ST_ARMED;
          end
        end
        ST_WAIT_DL: begin
          if (led_fall_s) begin
            state_nxt_s = ST_ARMED;
          end else begin
            state_nxt_s = ST_WAIT_DL;
          end
        end
        ST_ARMED: begin
          if (start_hit_s) begin
            state_nxt_s  = ST_DUMP;
            dump_start_s = 1'b1;
          end else begin
            state_nxt_s = ST_ARMED;
          end
        end
        ST_DUMP: begin
          if (stop_hit_s) begin
            state_nxt_s = ST_DONE;
            dump_stop_s = 1'b1;
          end else begin
            state_nxt_s = ST_DUMP;
          end
        end
        ST_DONE: begin
          if (rearm) begin
            state_nxt_s = ST_ARMED;
          end else begin
            state_nxt_s = ST_DONE;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
  end

  // State register and registered window level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      dump_en_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      dump_en_r <= (state_nxt_s == ST_DUMP);
    end
  end

  assign frame_cnt  = frame_cnt_r;
  assign vs_fall    = vs_fall_s;
  assign dump_en    = dump_en_r;
  assign dump_start = dump_start_s;
  assign dump_stop  = dump_stop_s;
  assign state      = state_r;

endmodule

// File: tb/tb_sim_frame_trigger.sv
// Directed bench: instance 0 has a fixed 2..5 window without download wait,
// instance 1 waits for a download and opens an endless window at frame 0.
module tb_sim_frame_trigger;

  logic        clk;
  logic        rst_n;
  logic        vga_vs     [2];
  logic        led        [2];
  logic        rearm      [2];
  logic [31:0] frame_cnt  [2];
  logic        vs_fall    [2];
  logic        dump_en    [2];
  logic        dump_start [2];
  logic        dump_stop  [2];
  logic [2:0]  state      [2];

  int n_checks = 0;
  int n_errors = 0;

  sim_frame_trigger #(.START_FRAME(32'd2), .LEN_FRAMES(32'd3), .WAIT_DL(1'b0)) u_a (
    .clk(clk), .rst_n(rst_n), .VGA_VS(vga_vs[0]), .led(led[0]), .rearm(rearm[0]),
    .frame_cnt(frame_cnt[0]), .vs_fall(vs_fall[0]), .dump_en(dump_en[0]),
    .dump_start(dump_start[0]), .dump_stop(dump_stop[0]), .state(state[0])
  );

  sim_frame_trigger #(.START_FRAME(32'd0), .LEN_FRAMES(32'd0), .WAIT_DL(1'b1)) u_b (
    .clk(clk), .rst_n(rst_n), .VGA_VS(vga_vs[1]), .led(led[1]), .rearm(rearm[1]),
    .frame_cnt(frame_cnt[1]), .vs_fall(vs_fall[1]), .dump_en(dump_en[1]),
    .dump_start(dump_start[1]), .dump_stop(dump_stop[1]), .state(state[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One VS frame on instance d; reports what was seen in the vs_fall cycle.
  task automatic frame(input int d, output logic seen, output logic [31:0] cnt_at,
                       output logic start_at, output logic stop_at);
    seen = 1'b0; cnt_at = 32'd0; start_at = 1'b0; stop_at = 1'b0;
    @(negedge clk);
    vga_vs[d] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (vs_fall[d] && !seen) begin
        seen     = 1'b1;
        cnt_at   = frame_cnt[d];
        start_at = dump_start[d];
        stop_at  = dump_stop[d];
      end
    end
    vga_vs[d] = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  logic        seen, st, sp, en_ok, start_again, stop_any;
  logic [31:0] cnt_at;
  int          stop_cnt;

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      vga_vs[d] = 1'b1; led[d] = 1'b0; rearm[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    check_val("rst_cnt_a", frame_cnt[0], 32'd0);
    check_val("rst_state_a", 32'(state[0]), 32'd0);
    check_val("rst_en_a", 32'(dump_en[0]), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_val("arm_state_a", 32'(state[0]), 32'd2);
    check_val("waitdl_state_b", 32'(state[1]), 32'd1);

    // Window 2..5 on instance 0
    for (int f = 0; f < 8; f++) begin
      frame(0, seen, cnt_at, st, sp);
      check_val("a_seen", 32'(seen), 32'd1);
      check_val("a_cnt_at", cnt_at, 32'(f));
      check_val("a_start", 32'(st), 32'((f == 2) ? 1 : 0));
      check_val("a_stop", 32'(sp), 32'((f == 5) ? 1 : 0));
      check_val("a_en", 32'(dump_en[0]), 32'((f >= 2 && f <= 4) ? 1 : 0));
    end
    check_val("a_done", 32'(state[0]), 32'd4);
    check_val("a_cnt8", frame_cnt[0], 32'd8);

    // Download on instance 1 while VS toggles
    led[1] = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      vga_vs[1] = ((i % 16) < 8) ? 1'b0 : 1'b1;
    end
    vga_vs[1] = 1'b1;
    check_val("b_dl_cnt", frame_cnt[1], 32'd0);
    check_val("b_dl_state", 32'(state[1]), 32'd1);
    led[1] = 1'b0;
    repeat (6) @(negedge clk);
    check_val("b_armed", 32'(state[1]), 32'd2);
    check_val("b_cnt0", frame_cnt[1], 32'd0);

    // Endless window from frame 0
    frame(1, seen, cnt_at, st, sp);
    check_val("b_first_cnt", cnt_at, 32'd0);
    check_val("b_first_start", 32'(st), 32'd1);
    en_ok = 1'b1; start_again = 1'b0; stop_any = 1'b0;
    for (int k = 0; k < 50; k++) begin
      en_ok = en_ok & dump_en[1];
      frame(1, seen, cnt_at, st, sp);
      start_again = start_again | st;
      stop_any    = stop_any | sp | ~seen;
    end
    en_ok = en_ok & dump_en[1];
    check_val("b_en_50", 32'(en_ok), 32'd1);
    check_val("b_no_restart", 32'(start_again), 32'd0);
    check_val("b_no_stop", 32'(stop_any), 32'd0);
    check_val("b_cnt51", frame_cnt[1], 32'd51);

    // Download abort during the window
    stop_cnt = 0;
    led[1] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (dump_stop[1]) stop_cnt++;
    end
    check_val("b_abort_stop", 32'(stop_cnt), 32'd1);
    check_val("b_abort_en", 32'(dump_en[1]), 32'd0);
    check_val("b_abort_cnt", frame_cnt[1], 32'd0);
    check_val("b_abort_state", 32'(state[1]), 32'd1);

    // Rearm from DONE, then wrap the counter
    @(negedge clk);
    rearm[0] = 1'b1;
    @(negedge clk);
    rearm[0] = 1'b0;
    check_val("a_rearm", 32'(state[0]), 32'd2);
    force u_a.frame_cnt_r = 32'hFFFF_FFFF;
    #1;
    release u_a.frame_cnt_r;
    for (int f = 0; f < 4; f++) begin
      frame(0, seen, cnt_at, st, sp);
      check_val("wrap_cnt_at", cnt_at, (f == 0) ? 32'hFFFF_FFFF : 32'(f - 1));
      check_val("wrap_start", 32'(st), 32'((f == 3) ? 1 : 0));
    end
    check_val("wrap_en", 32'(dump_en[0]), 32'd1);
    check_val("wrap_state", 32'(state[0]), 32'd3);
    @(negedge clk);
    rearm[0] = 1'b1;
    @(negedge clk);
    rearm[0] = 1'b0;
    check_val("rearm_ignored", 32'(state[0]), 32'd3);

    // Asynchronous reset in the middle of the window
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("async_cnt", frame_cnt[0], 32'd0);
    check_val("async_vsf", 32'(vs_fall[0]), 32'd0);
    check_val("async_en", 32'(dump_en[0]), 32'd0);
    check_val("async_start", 32'(dump_start[0]), 32'd0);
    check_val("async_stop", 32'(dump_stop[0]), 32'd0);
    check_val("async_state", 32'(state[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_val("post_rst_idle", 32'(state[0]), 32'd0);
    @(negedge clk);
    check_val("post_rst_armed", 32'(state[0]), 32'd2);
    check_val("post_rst_b", 32'(state[1]), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
